// File: rtl/pipe_pkg.sv
// Shared pipeline types: access sizes, register width, control bundle.
package pipe_pkg;

  localparam logic [1:0] ACC_BYTE = 2'd0;
  localparam logic [1:0] ACC_HALF = 2'd1;
  localparam logic [1:0] ACC_WORD = 2'd2;

  localparam int REG_AW = 5;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] acc_size;
  } ctrl_t;

endpackage

// File: rtl/acc_align_check.sv
// Combinational access-size alignment check (LSB at highest byte address).
module acc_align_check
  import pipe_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  input  logic       mem_en,
  output logic       misalign
);

  logic w_bad;

  // Size 3 is reserved and checked as a word.
  always_comb begin
    w_bad = 1'b0;
    case (size)
      ACC_BYTE: w_bad = 1'b0;
      ACC_HALF: w_bad = ~addr[0];
      default:  w_bad = (addr != 2'b11);
    endcase
  end

  assign misalign = mem_en & w_bad;

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE/MEM pipeline register with stall, flush, alignment check, stall counter.
// Optional MISALIGN_TRAP_EN: suppress misaligned accesses, sticky Misalign.
module exe_mem_stage_reg #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       EXE_ALU_Result,
  input  logic [31:0]       EXE_Rt,
  input  logic [REG_AW-1:0] EXE_WriteReg,
  input  logic              EXE_MemRead,
  input  logic              EXE_MemWrite,
  input  logic              EXE_RegWrite,
  input  logic              EXE_MemToReg,
  input  logic [1:0]        EXE_AccSize,
  output logic [31:0]       EXE_MEM_Address,
  output logic [31:0]       EXE_MEM_Rt,
  output logic [REG_AW-1:0] EXE_MEM_WriteReg,
  output logic              EXE_MEM_MemRead,
  output logic              EXE_MEM_MemWrite,
  output logic              EXE_MEM_RegWrite,
  output logic              EXE_MEM_MemToReg,
  output logic [1:0]        EXE_MEM_AccSize,
  output logic              EXE_MEM_Valid,
  output logic              Misalign,
  output logic [CNT_W-1:0]  StallCount
);

  import pipe_pkg::*;

  logic [31:0]       r_addr;
  logic [31:0]       r_rt;
  logic [REG_AW-1:0] r_wreg;
  ctrl_t             r_ctrl;
  logic              r_valid;
  logic              r_mis;
  logic [CNT_W-1:0]  r_cnt;

  ctrl_t w_ctrl;
  ctrl_t w_cap_ctrl;
  logic  w_mis;
  logic  w_cnt_max;

  acc_align_check u_align (
    .addr     (EXE_ALU_Result[1:0]),
    .size     (EXE_AccSize),
    .mem_en   (EXE_MemRead | EXE_MemWrite),
    .misalign (w_mis)
  );

  always_comb begin
    w_ctrl            = '0;
    w_ctrl.mem_read   = EXE_MemRead;
    w_ctrl.mem_write  = EXE_MemWrite;
    w_ctrl.reg_write  = EXE_RegWrite;
    w_ctrl.mem_to_reg = EXE_MemToReg;
    w_ctrl.acc_size   = EXE_AccSize;
  end

`ifdef MISALIGN_TRAP_EN
  // A trapped access must never reach memory or the register file.
  always_comb begin
    w_cap_ctrl = w_ctrl;
    if (w_mis) begin
      w_cap_ctrl.mem_read  = 1'b0;
      w_cap_ctrl.mem_write = 1'b0;
      w_cap_ctrl.reg_write = 1'b0;
    end
  end
`else
  assign w_cap_ctrl = w_ctrl;
`endif

  assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_rt    <= '0;
      r_wreg  <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_addr  <= '0;
      r_rt    <= '0;
      r_wreg  <= '0;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
`ifndef MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
    end else if (stall) begin
      if (r_valid && !w_cnt_max)
        r_cnt <= r_cnt + 1'b1;
    end else begin
      r_addr  <= EXE_ALU_Result;
      r_rt    <= EXE_Rt;
      r_wreg  <= EXE_WriteReg;
      r_ctrl  <= w_cap_ctrl;
      r_valid <= 1'b1;
`ifdef MISALIGN_TRAP_EN
      r_mis   <= r_mis | w_mis;
`else
      r_mis   <= w_mis;
`endif
    end
  end

  assign EXE_MEM_Address  = r_addr;
  assign EXE_MEM_Rt       = r_rt;
  assign EXE_MEM_WriteReg = r_wreg;
  assign EXE_MEM_MemRead  = r_ctrl.mem_read;
  assign EXE_MEM_MemWrite = r_ctrl.mem_write;
  assign EXE_MEM_RegWrite = r_ctrl.reg_write;
  assign EXE_MEM_MemToReg = r_ctrl.mem_to_reg;
  assign EXE_MEM_AccSize  = r_ctrl.acc_size;
  assign EXE_MEM_Valid    = r_valid;
  assign Misalign         = r_mis;
  assign StallCount       = r_cnt;

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- EXE/MEM pipeline register; sits directly upstream of the data memory.
- Registers the ALU result (memory address), store data (Rt), destination register and memory/write-back controls at the end of EXE.
- Supports stall (hold) and flush (bubble insertion), checks access-size alignment, and counts stall cycles for performance debug.
- Output names match the data-memory inputs (EXE_MEM_Address, EXE_MEM_Rt, MemRead, MemWrite), so the two blocks connect directly.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- stall  in  1  hold all registered state this cycle.
- flush  in  1  replace the captured entry with a bubble.
- EXE_ALU_Result  in  32  effective address / ALU result.
- EXE_Rt  in  32  store data.
- EXE_WriteReg  in  REG_AW  destination register.
- EXE_MemRead, EXE_MemWrite, EXE_RegWrite, EXE_MemToReg  in  1 each  controls.
- EXE_AccSize  in  2  0=byte, 1=half, 2=word; 3 is reserved and treated as word.
- EXE_MEM_Address  out  32  registered address.
- EXE_MEM_Rt  out  32  registered store data.
- EXE_MEM_WriteReg  out  REG_AW  registered destination.
- EXE_MEM_MemRead, EXE_MEM_MemWrite, EXE_MEM_RegWrite, EXE_MEM_MemToReg  out  1 each  registered controls.
- EXE_MEM_AccSize  out  2  registered size.
- EXE_MEM_Valid  out  1  the entry is a real instruction, not a bubble.
- Misalign  out  1  registered alignment fault.
- StallCount  out  CNT_W  saturating count of stalled valid cycles.

Behaviour:
- Reset: asynchronous; clears every output to 0, including Valid, Misalign and StallCount. Deassertion takes effect at the next rising clk edge.
- Latency: 1 cycle, capture to output.
- Priority at each posedge, highest first: rst, flush, stall, capture.
- flush: controls, Valid, WriteReg, AccSize, Address, Rt and Misalign all go to 0. StallCount is unchanged. flush overrides a simultaneous stall.
- stall (without flush): all pipeline outputs hold their values. StallCount increments by 1 if EXE_MEM_Valid=1, and saturates at all-ones (no wrap).
- capture: all EXE_* inputs are registered, and Valid is set to 1.
- Alignment convention: a word is addressed by its least-significant byte, which sits at the highest byte address (data memory is big-endian, address-3 holds bits 31:24).
  - word requires Address[1:0]=2'b11.
  - half requires Address[0]=1.
  - byte is always aligned.
- Misalign: computed combinationally from the EXE_* inputs and registered at capture. It is 1 only if (EXE_MemRead or EXE_MemWrite) and the address is unaligned. It is 0 for non-memory instructions regardless of address.
- Simultaneous EXE_MemRead and EXE_MemWrite: both are passed through unchanged; detecting this is upstream's responsibility. Misalign follows the same alignment rule.
- Reset mid-stall: the entry is lost and the counter clears. No replay.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access is captured with EXE_MEM_MemRead, EXE_MEM_MemWrite and EXE_MEM_RegWrite forced to 0, so the memory is never touched. Valid stays 1.
  - Misalign is sticky: once set it stays 1 until rst (flush does not clear it).
- Undefined:
  - The access passes through unchanged.
  - Misalign is a per-entry flag that is recomputed at every capture and cleared by flush.

Decomposition:
- Shared package (pipe_pkg):
  - ACC_BYTE=2'd0, ACC_HALF=2'd1, ACC_WORD=2'd2.
  - REG_AW default.
  - A struct typedef for the control bundle (MemRead, MemWrite, RegWrite, MemToReg, AccSize).
- One sub-module, acc_align_check: a purely combinational alignment check.
  - Inputs: addr[1:0], size, mem_en.
  - Output: misalign.
  - It will be reused by the later MEM/WB stage.

Test Plan:
- Reset: assert rst mid-cycle with Valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
- Capture: Address=0x00000007, Rt=0xDEADBEEF, MemWrite=1, AccSize=word -> next cycle EXE_MEM_Address=0x7, EXE_MEM_Rt=0xDEADBEEF, EXE_MEM_MemWrite=1, Valid=1, Misalign=0.
- Stall: 3 cycles of stall with a valid entry and changing inputs -> outputs frozen, StallCount=3. A stall with Valid=0 leaves StallCount unchanged.
- Flush vs stall: flush=1 and stall=1 on the same edge -> bubble, i.e. all controls 0 and Valid=0.
- Misalign: Address=0x00000004, AccSize=word, MemRead=1 -> Misalign=1.
  - Without MISALIGN_TRAP_EN: EXE_MEM_MemRead=1.
  - With MISALIGN_TRAP_EN: EXE_MEM_MemRead=0, and Misalign stays 1 after a following aligned load (Address=0x0B).
- Saturation: with CNT_W=4, 20 stalled valid cycles -> StallCount=15.
